// File: rtl/eif_spike_monitor_if.sv
// Event output port of eif_spike_monitor: valid/ready handshake plus event word fields.
interface eif_spike_monitor_if #(
  parameter int ISI_W = 16
);
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_first;
  logic             evt_sat;
  logic [ISI_W-1:0] evt_isi;
  logic [7:0]       evt_state;

  modport master (
    output evt_valid,
    output evt_first,
    output evt_sat,
    output evt_isi,
    output evt_state,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_first,
    input  evt_sat,
    input  evt_isi,
    input  evt_state,
    output evt_ready
  );
endinterface

// File: rtl/eif_spike_monitor.sv
// eif_spike_monitor: detects rising edges of the neuron spike, measures the
// inter-spike interval in enabled cycles and queues event words in a small
// first-word-fall-through FIFO drained through a valid/ready port.
module eif_spike_monitor #(
  parameter int ISI_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  spike_in,
  input  logic [7:0]            state_in,
  eif_spike_monitor_if.master   evt,
  output logic [15:0]           spike_count,
  output logic [7:0]            drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = ISI_W + 10;
  localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_ONE  = ISI_W'(1);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  // Event word layout: {first, sat, isi[ISI_W-1:0], state[7:0]}
  logic             spike_d;
  logic             first_pending;
  logic [ISI_W-1:0] isi_cnt;
  logic [WW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic             hit;
  logic             not_empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [WW-1:0]    evt_word;
  logic [WW-1:0]    head;

  // Edge detect, handshake decode and event word assembly.
  always_comb begin
    hit       = ena & spike_in & ~spike_d;
    not_empty = (count != '0);
    full      = (count == CNT_FULL);
    pop       = not_empty & evt.evt_ready;
    push      = hit & (~full | pop);
    drop      = hit & full & ~pop;
    if (first_pending) begin
      evt_word = {1'b1, 1'b0, {ISI_W{1'b0}}, state_in};
    end else begin
      evt_word = {1'b0, (isi_cnt == ISI_MAX), isi_cnt, state_in};
    end
  end

  // Spike history, ISI counter and first-event flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_d       <= 1'b0;
      isi_cnt       <= '0;
      first_pending <= 1'b1;
    end else begin
      spike_d <= spike_in;
      if (hit) begin
        isi_cnt       <= ISI_ONE;
        first_pending <= 1'b0;
      end else if (ena && (isi_cnt != ISI_MAX)) begin
        isi_cnt <= isi_cnt + ISI_ONE;
      end else begin
        isi_cnt <= isi_cnt;
      end
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= evt_word;
    end
  end

  // FIFO pointers and occupancy; pop and push may coincide when non-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Running spike counter (wrapping) and drop counter (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_count <= 16'd0;
      drop_count  <= 8'd0;
    end else begin
      if (hit) begin
        spike_count <= spike_count + 16'd1;
      end
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Head of FIFO onto the event port, forced to zero while empty.
  always_comb begin
    head          = mem[rd_ptr];
    evt.evt_valid = not_empty;
    if (not_empty) begin
      evt.evt_first = head[WW-1];
      evt.evt_sat   = head[WW-2];
      evt.evt_isi   = head[ISI_W+7:8];
      evt.evt_state = head[7:0];
    end else begin
      evt.evt_first = 1'b0;
      evt.evt_sat   = 1'b0;
      evt.evt_isi   = '0;
      evt.evt_state = 8'd0;
    end
  end

endmodule

// File: tb/tb_eif_spike_monitor.sv
// Self-checking bench for eif_spike_monitor: directed table, hand-written
// corner sequences and randomized traffic against an event-level model.
module tb_eif_spike_monitor;

  localparam int DEPTH   = 4;
  localparam longint MAX16 = 65535;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        spike_in;
  logic [7:0]  state_in;
  logic        ready;
  logic [15:0] spike_count;
  logic [7:0]  drop_count;
  logic [15:0] spike_count2;
  logic [7:0]  drop_count2;

  eif_spike_monitor_if #(.ISI_W(16)) bus ();
  eif_spike_monitor_if #(.ISI_W(4))  bus2 ();

  assign bus.evt_ready  = ready;
  assign bus2.evt_ready = 1'b1;

  eif_spike_monitor #(.ISI_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .state_in(state_in),
    .evt(bus.master), .spike_count(spike_count), .drop_count(drop_count)
  );

  eif_spike_monitor #(.ISI_W(4), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .spike_in(spike_in), .state_in(state_in),
    .evt(bus2.master), .spike_count(spike_count2), .drop_count(drop_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        first;
    logic        sat;
    logic [15:0] isi;
    logic [7:0]  state;
  } ev_t;

  // Reference model state: an event queue and enabled-cycle timestamps.
  ev_t         mq[$];
  bit          m_spike_prev;
  bit          m_first;
  longint      m_en_idx;
  longint      m_last_idx;
  int          m_spikes;
  int          m_drops;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_spike_prev = 1'b0;
    m_first      = 1'b1;
    m_en_idx     = 0;
    m_last_idx   = 0;
    m_spikes     = 0;
    m_drops      = 0;
  endtask

  task automatic check_all();
    ev_t h;
    bit  v;
    v = (mq.size() != 0);
    if (v) h = mq[0];
    else begin
      h.first = 1'b0; h.sat = 1'b0; h.isi = 16'd0; h.state = 8'd0;
    end
    chk("valid", {31'd0, bus.evt_valid}, {31'd0, v});
    chk("first", {31'd0, bus.evt_first}, {31'd0, h.first});
    chk("sat",   {31'd0, bus.evt_sat},   {31'd0, h.sat});
    chk("isi",   {16'd0, bus.evt_isi},   {16'd0, h.isi});
    chk("state", {24'd0, bus.evt_state}, {24'd0, h.state});
    chk("spike_count", {16'd0, spike_count}, 32'(m_spikes & 16'hFFFF));
    chk("drop_count",  {24'd0, drop_count},  32'(m_drops));
  endtask

  // One clock cycle: model consumes current inputs, DUT clocks, then compare.
  task automatic tick();
    bit     edge_s;
    bit     pop;
    longint d;
    ev_t    w;
    edge_s = ena && spike_in && !m_spike_prev;
    pop    = (mq.size() != 0) && ready;
    w.first = 1'b0; w.sat = 1'b0; w.isi = 16'd0; w.state = state_in;
    if (edge_s) begin
      if (m_first) begin
        w.first = 1'b1;
      end else begin
        d = m_en_idx - m_last_idx;
        if (d >= MAX16) begin
          w.isi = 16'hFFFF;
          w.sat = 1'b1;
        end else begin
          w.isi = 16'(d);
        end
      end
      m_first    = 1'b0;
      m_last_idx = m_en_idx;
    end
    if (ena) m_en_idx++;
    m_spike_prev = spike_in;
    if (pop) void'(mq.pop_front());
    if (edge_s) begin
      m_spikes++;
      if (mq.size() < DEPTH) mq.push_back(w);
      else if (m_drops < 255) m_drops++;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ena      = 1'b0;
    spike_in = 1'b0;
    ready    = 1'b0;
    state_in = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  // Emit 1-cycle spikes every other cycle with given state tags.
  task automatic spike_train(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      spike_in = 1'b1; state_in = base + 8'(k); tick();
      spike_in = 1'b0; tick();
    end
  endtask

  typedef struct {
    int          cyc;
    logic [7:0]  state;
    logic        first;
    logic [15:0] isi;
  } vec_t;

  vec_t vecs[3];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; ena = 1'b0; spike_in = 1'b0; ready = 1'b0; state_in = 8'd0;
    model_reset();

    vecs[0] = '{cyc: 10, state: 8'd10, first: 1'b1, isi: 16'd0};
    vecs[1] = '{cyc: 25, state: 8'd25, first: 1'b0, isi: 16'd15};
    vecs[2] = '{cyc: 27, state: 8'd27, first: 1'b0, isi: 16'd2};

    // Basic ISI from the vector table
    do_reset();
    ena = 1'b1; ready = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      int hitk;
      hitk = -1;
      for (int k = 0; k < 3; k++) if (vecs[k].cyc == c) hitk = k;
      spike_in = (hitk >= 0);
      state_in = 8'(c);
      tick();
      if (hitk >= 0) begin
        chk("tbl_valid", {31'd0, bus.evt_valid}, 32'd1);
        chk("tbl_first", {31'd0, bus.evt_first}, {31'd0, vecs[hitk].first});
        chk("tbl_isi",   {16'd0, bus.evt_isi},   {16'd0, vecs[hitk].isi});
        chk("tbl_state", {24'd0, bus.evt_state}, {24'd0, vecs[hitk].state});
      end
    end
    chk("tbl_spike_count", {16'd0, spike_count}, 32'd3);

    // Held spike, then ena low with an ignored pulse
    do_reset();
    ena = 1'b1; ready = 1'b1; state_in = 8'h11;
    spike_in = 1'b1;
    repeat (20) tick();
    spike_in = 1'b0;
    repeat (5) tick();
    ena = 1'b0;
    for (int c = 0; c < 50; c++) begin
      spike_in = (c >= 20 && c < 23);
      tick();
    end
    ena = 1'b1; spike_in = 1'b0;
    repeat (4) tick();
    spike_in = 1'b1; state_in = 8'h22;
    tick();
    chk("held_valid", {31'd0, bus.evt_valid}, 32'd1);
    chk("held_first", {31'd0, bus.evt_first}, 32'd0);
    chk("held_isi",   {16'd0, bus.evt_isi},   32'd29);
    chk("held_spikes", {16'd0, spike_count}, 32'd2);
    spike_in = 1'b0;
    tick();

    // Overflow: 6 spikes into a 4-deep FIFO with no consumer
    do_reset();
    ena = 1'b1;
    spike_train(6, 8'hA0);
    chk("ovf_drop",  {24'd0, drop_count},  32'd2);
    chk("ovf_spike", {16'd0, spike_count}, 32'd6);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_valid", {31'd0, bus.evt_valid}, 32'd1);
      chk("ovf_drain_state", {24'd0, bus.evt_state}, 32'(8'hA0 + k));
      tick();
    end
    chk("ovf_empty", {31'd0, bus.evt_valid}, 32'd0);

    // Full FIFO with push and pop in the same cycle
    do_reset();
    ena = 1'b1;
    spike_train(4, 8'hB0);
    spike_in = 1'b1; state_in = 8'hB4; ready = 1'b1;
    tick();
    spike_in = 1'b0; ready = 1'b0;
    tick();
    chk("fp_drop",  {24'd0, drop_count},  32'd0);
    chk("fp_spike", {16'd0, spike_count}, 32'd5);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("fp_drain_valid", {31'd0, bus.evt_valid}, 32'd1);
      chk("fp_drain_state", {24'd0, bus.evt_state}, 32'(8'hB0 + k));
      tick();
    end
    chk("fp_empty", {31'd0, bus.evt_valid}, 32'd0);

    // Saturation on the 4-bit ISI instance, plus a just-below-max interval
    do_reset();
    ena = 1'b1; ready = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      spike_in = (c == 0 || c == 40 || c == 55 || c == 69);
      state_in = 8'(c);
      tick();
      if (c == 0) begin
        chk("sat_first_valid", {31'd0, bus2.evt_valid}, 32'd1);
        chk("sat_first_flag",  {31'd0, bus2.evt_first}, 32'd1);
        chk("sat_first_isi",   {28'd0, bus2.evt_isi},   32'd0);
      end
      if (c == 40 || c == 55) begin
        chk("sat_isi",  {28'd0, bus2.evt_isi}, 32'd15);
        chk("sat_flag", {31'd0, bus2.evt_sat}, 32'd1);
        chk("sat_nf",   {31'd0, bus2.evt_first}, 32'd0);
      end
      if (c == 69) begin
        chk("nsat_isi",  {28'd0, bus2.evt_isi}, 32'd14);
        chk("nsat_flag", {31'd0, bus2.evt_sat}, 32'd0);
      end
    end

    // Asynchronous reset with three events queued
    do_reset();
    ena = 1'b1;
    spike_train(3, 8'hC0);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.evt_valid}, 32'd0);
    chk("rst_spike", {16'd0, spike_count}, 32'd0);
    chk("rst_drop",  {24'd0, drop_count},  32'd0);
    chk("rst_isi",   {16'd0, bus.evt_isi}, 32'd0);
    chk("rst_state", {24'd0, bus.evt_state}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    spike_in = 1'b1; state_in = 8'h33;
    tick();
    chk("rst_next_first", {31'd0, bus.evt_first}, 32'd1);
    chk("rst_next_state", {24'd0, bus.evt_state}, 32'h33);
    spike_in = 1'b0;
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      ena      = ($urandom_range(0, 3) != 0);
      spike_in = ($urandom_range(0, 2) == 0);
      state_in = 8'($urandom);
      if (((i / 100) % 2) == 1) ready = ($urandom_range(0, 3) == 0);
      else                      ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
